ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Instruction-fetch controller: consumer of the PC register's value and driver of its next_pc/hold inputs.
//  - Issues a read to instruction memory, which may stall.
//  - Presents each fetched word to decode over a valid/ready handshake.
//  - Holds the PC while memory or decode stalls; on a branch/jump redirect, discards any in-flight word.
// PARAMETERS
//  AW         16        address / PC width
//  DW         16        instruction width
//  NOP_INSTR  16'h0800  value driven on if_instr when no valid instruction
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  pc           in   AW  current PC register value
//  pc_hold      out  1   1 = PC keeps its value; 0 = PC loads next_pc at next edge
//  next_pc      out  AW  value PC loads when pc_hold=0
//  redirect     in   1   branch/jump taken (one-cycle pulse from execute)
//  redirect_pc  in   AW  target address, valid with redirect
//  mem_rd       out  1   read request; held high until mem_done
//  mem_addr     out  AW  request address; registered, stable while mem_rd=1
//  mem_data     in   DW  read data, valid with mem_done
//  mem_done     in   1   request completes this cycle
//  if_valid     out  1   instruction available to decode
//  if_instr     out  DW  fetched instruction (NOP_INSTR when if_valid=0)
//  if_pc        out  AW  address of if_instr
//  if_pc_plus2  out  AW  if_pc + 2 (mod 2^AW)
//  id_ready     in   1   decode accepts the instruction this cycle
//  halted       out  1   fetch stopped on HALT (tied 0 unless IFETCH_HALT_EN)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE.
//    - Outputs: mem_rd=0, mem_addr=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, pc_hold=1, next_pc=pc, halted=0.
//    - Reset mid-request abandons it; mem_rd drops the same cycle.
//  - States and transitions:
//    - IDLE: go to FETCH; latch mem_addr<=pc.
//    - FETCH: mem_rd=1.
//      - mem_done & !redirect: latch if_instr<=mem_data, if_pc<=mem_addr; go to DELIVER.
//      - mem_done & redirect: discard data, pc_hold=0, next_pc=redirect_pc; go to IDLE.
//      - !mem_done & redirect: pc_hold=0, next_pc=redirect_pc; go to DROP.
//    - DROP: mem_rd=1, mem_addr unchanged; on mem_done discard data; go to IDLE. Further redirects in DROP also update PC.
//    - DELIVER: if_valid=1; if_instr/if_pc stable until left.
//      - redirect (wins over id_ready): pc_hold=0, next_pc=redirect_pc, instr dropped; go to IDLE.
//      - id_ready: pc_hold=0, next_pc=if_pc+2; go to IDLE.
//      - otherwise: hold, no new mem_rd.
//  - pc_hold=0 only in the transitions above; 1 in every other cycle.
//  - Latency:
//    - mem_rd rises one cycle after IDLE.
//    - if_valid rises the cycle after mem_done.
//    - Throughput 1 instr per 3 cycles with a 1-cycle memory.
//  - Arithmetic: +2 wraps, 16'hFFFE -> 16'h0000; no overflow flag.
//  - redirect outside FETCH/DROP/DELIVER (i.e. in IDLE) loads PC: pc_hold=0, next_pc=redirect_pc.
// CONFIGURATION
//  IFETCH_HALT_EN defined:
//    - In DELIVER, when if_instr[15:11]==5'b00000 and id_ready=1, go to HALTED.
//    - HALTED: halted=1, pc_hold=1, mem_rd=0, if_valid=0, redirect ignored; left only by reset.
//  IFETCH_HALT_EN undefined: HALT opcode is an ordinary instruction; halted tied 0; no HALTED state.
// STRUCTURE
//  - ifetch_pkg: state enum (IDLE, FETCH, DROP, DELIVER, HALTED), NOP_INSTR, OPC_HALT=5'b00000, PC_INC=2.
//  - Sub-module ifetch_buf: if_instr/if_pc/if_valid holding register with load/clear; FSM stays in ifetch_ctrl.
// TESTING
//  1. Reset and startup:
//     - Hold rst_n=0 with pc=0 -> mem_rd=0, if_valid=0, if_instr=16'h0800, pc_hold=1.
//     - Release -> mem_rd=1, mem_addr=16'h0000 on 2nd posedge.
//  2. 1-cycle memory (mem_done with mem_rd), id_ready=1:
//     - if_pc sequence 0000, 0002, 0004 with matching data; pc_hold=0 once per instr.
//  3. mem_done delayed 3 cycles -> mem_addr constant, if_valid=0 until cycle after mem_done.
//  4. id_ready=0 for 4 cycles in DELIVER -> if_instr/if_pc stable, pc_hold=1, mem_rd=0; accept on 5th.
//  5. Redirect to 16'h0040 while a request is stalled:
//     - pc_hold=0, next_pc=0040 that cycle.
//     - Stale data never raises if_valid; next mem_addr=0040.
//  6. Wrap and halt:
//     - Accept at if_pc=FFFE -> next_pc=0000.
//     - With IFETCH_HALT_EN, deliver 16'h0000 and accept -> halted=1; no further mem_rd for 10 cycles despite redirect.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared state encoding and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DROP    = 3'd2,
        DELIVER = 3'd3,
        HALTED  = 3'd4
    } ifetch_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam int          PC_INC    = 2;

endpackage

// File: rtl/ifetch_buf.sv
// Holding register for the word presented to decode: loads on a completed fetch,
// clears when decode takes it or it is dropped.
module ifetch_buf #(
    parameter int              AW        = 16,
    parameter int              DW        = 16,
    parameter logic [DW-1:0]   NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] load_instr,
    input  logic [AW-1:0] load_pc,
    output logic          valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc
);

    logic [DW-1:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            instr_q <= NOP_INSTR;
            pc      <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            instr_q <= load_instr;
            pc      <= load_pc;
        end else if (clear) begin
            valid   <= 1'b0;
        end
    end

    // if_pc keeps the last address after a clear; only the instruction is masked.
    assign instr = valid ? instr_q : NOP_INSTR;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, requests words from memory
// and hands them to decode. Optional HALT support under IFETCH_HALT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | latch fetch address from PC, request starts next cycle
// FETCH   | memory read outstanding
// DROP    | read outstanding but redirected; data will be discarded
// DELIVER | word presented to decode, waiting for id_ready
// HALTED  | HALT accepted, fetch stopped until reset (IFETCH_HALT_EN)
module ifetch_ctrl #(
    parameter int            AW        = 16,
    parameter int            DW        = 16,
    parameter logic [DW-1:0] NOP_INSTR = 16'h0800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    output logic          pc_hold,
    output logic [AW-1:0] next_pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          mem_done,
    output logic          if_valid,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc_plus2,
    input  logic          id_ready,
    output logic          halted
);

    import ifetch_pkg::*;

    ifetch_state_e state_q, state_d;
    logic          addr_ld;
    logic [AW-1:0] addr_d;
    logic          buf_load;
    logic          buf_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mem_addr <= '0;
        end else begin
            state_q <= state_d;
            if (addr_ld) begin
                mem_addr <= addr_d;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_hold   = 1'b1;
        next_pc   = pc;
        addr_ld   = 1'b0;
        addr_d    = pc;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        mem_rd    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                addr_ld = 1'b1;
                // A redirect here also steers this fetch, so the stale PC is never read.
                if (redirect) begin
                    pc_hold = 1'b0;
                    next_pc = redirect_pc;
                    addr_d  = redirect_pc;
                end
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (redirect) begin
                    pc_hold = 1'b0;
                    next_pc = redirect_pc;
                    state_d = mem_done ? IDLE : DROP;
                end else if (mem_done) begin
                    buf_load = 1'b1;
                    state_d  = DELIVER;
                end
            end
            DROP: begin
                mem_rd = 1'b1;
                if (redirect) begin
                    pc_hold = 1'b0;
                    next_pc = redirect_pc;
                end
                if (mem_done) begin
                    state_d = IDLE;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    pc_hold   = 1'b0;
                    next_pc   = redirect_pc;
                    buf_clear = 1'b1;
                    state_d   = IDLE;
                end else if (id_ready) begin
                    buf_clear = 1'b1;
`ifdef IFETCH_HALT_EN
                    if (if_instr[DW-1:DW-5] == OPC_HALT) begin
                        state_d = HALTED;
                    end else begin
                        pc_hold = 1'b0;
                        next_pc = if_pc_plus2;
                        state_d = IDLE;
                    end
`else
                    pc_hold = 1'b0;
                    next_pc = if_pc_plus2;
                    state_d = IDLE;
`endif
                end
            end
`ifdef IFETCH_HALT_EN
            HALTED: begin
                halted = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ifetch_buf #(
        .AW        (AW),
        .DW        (DW),
        .NOP_INSTR (NOP_INSTR)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (mem_data),
        .load_pc    (mem_addr),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    assign if_pc_plus2 = if_pc + AW'(PC_INC);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed vector table, reset corner cases,
// and a randomized run checked against a fetch-stream reference model.
module tb_ifetch_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        pc_hold;
    logic [15:0] next_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_done;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        id_ready;
    logic        halted;

    ifetch_ctrl #(.AW(16), .DW(16), .NOP_INSTR(16'h0800)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_hold     (pc_hold),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_done    (mem_done),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .id_ready    (id_ready),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        d;
        logic [15:0] dat;
        logic        r;
        logic [15:0] rp;
        logic        rdy;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_v;
        logic [15:0] e_instr;
        logic [15:0] e_ifpc;
        logic        e_hold;
        logic [15:0] e_next;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic d, input logic [15:0] dat, input logic r,
                                 input logic [15:0] rp, input logic rdy, input logic e_rd,
                                 input logic [15:0] e_addr, input logic e_v,
                                 input logic [15:0] e_instr, input logic [15:0] e_ifpc,
                                 input logic e_hold, input logic [15:0] e_next);
        vec_t v;
        v.d = d; v.dat = dat; v.r = r; v.rp = rp; v.rdy = rdy;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v; v.e_instr = e_instr;
        v.e_ifpc = e_ifpc; v.e_hold = e_hold; v.e_next = e_next;
        return v;
    endfunction

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        logic [14:0] h;
        h = (a[14:0] * 15'd13) ^ 15'h2A5B;
        return {1'b1, h};
    endfunction

    // Called just after a negedge; applies inputs and lets combinational outputs settle.
    task automatic drive(input logic d, input logic [15:0] dat, input logic r,
                         input logic [15:0] rp, input logic rdy);
        mem_done    = d;
        mem_data    = dat;
        redirect    = r;
        redirect_pc = rp;
        id_ready    = rdy;
        #1;
    endtask

    // Models the PC register, then returns to the next negedge.
    task automatic advance();
        logic [15:0] pcn;
        pcn = pc_hold ? pc : next_pc;
        @(posedge clk);
        #1;
        pc = pcn;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pc    = 16'h0000;
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic        req_active;
    logic [15:0] req_addr;
    int          lat;
    int          waited;
    logic [15:0] exp_pc;
    int          accepts;
    logic        r_d, r_r, r_rdy;
    logic [15:0] r_dat, r_rp, inc;

    initial begin
        rst_n = 1'b0;
        pc = 16'h0000;
        mem_done = 1'b0; mem_data = 16'h0000; redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b0;

        // Startup, 1-cycle memory, slow memory, decode back-pressure, redirects, wrap.
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h1111, 0, 16'h0000, 0, 1, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1111, 16'h0000, 0, 16'h0002));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h2222, 0, 16'h0000, 0, 1, 16'h0002, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h2222, 16'h0002, 0, 16'h0004));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        for (int i = 0; i < 3; i++)
            vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 0, NOP,   16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h3333, 0, 16'h0000, 0, 1, 16'h0004, 0, NOP,       16'h0000, 1, 16'h0000));
        for (int i = 0; i < 4; i++)
            vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3333, 16'h0004, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h3333, 16'h0004, 0, 16'h0006));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0006, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 1, 16'h0040, 0, 1, 16'h0006, 0, NOP,       16'h0000, 0, 16'h0040));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0006, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'hDEAD, 0, 16'h0000, 0, 1, 16'h0006, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h4444, 0, 16'h0000, 0, 1, 16'h0040, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h4444, 16'h0040, 0, 16'h0042));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h5555, 1, 16'hFFFE, 0, 1, 16'h0042, 0, NOP,       16'h0000, 0, 16'hFFFE));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h6666, 0, 16'h0000, 0, 1, 16'hFFFE, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h6666, 16'hFFFE, 0, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(1, 16'h7777, 0, 16'h0000, 0, 1, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 1, 16'h0100, 1, 0, 16'h0000, 1, 16'h7777, 16'h0000, 0, 16'h0100));
        vq.push_back(row(0, 16'h0000, 1, 16'h0200, 0, 0, 16'h0000, 0, NOP,       16'h0000, 0, 16'h0200));
        vq.push_back(row(1, 16'h8888, 0, 16'h0000, 0, 1, 16'h0200, 0, NOP,       16'h0000, 1, 16'h0000));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h8888, 16'h0200, 0, 16'h0202));
        vq.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, NOP,       16'h0000, 1, 16'h0000));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_rd", mem_rd, 1'b0);
        chk("rst if_valid", if_valid, 1'b0);
        chk("rst if_instr", if_instr, NOP);
        chk("rst pc_hold", pc_hold, 1'b1);
        chk("rst next_pc", next_pc, 16'h0000);
        chk("rst mem_addr", mem_addr, 16'h0000);
        chk("rst if_pc", if_pc, 16'h0000);
        chk("rst halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].d, vq[i].dat, vq[i].r, vq[i].rp, vq[i].rdy);
            chk($sformatf("row%0d mem_rd", i), mem_rd, vq[i].e_rd);
            if (vq[i].e_rd) chk($sformatf("row%0d mem_addr", i), mem_addr, vq[i].e_addr);
            chk($sformatf("row%0d if_valid", i), if_valid, vq[i].e_v);
            chk($sformatf("row%0d if_instr", i), if_instr, vq[i].e_instr);
            if (vq[i].e_v) begin
                chk($sformatf("row%0d if_pc", i), if_pc, vq[i].e_ifpc);
                inc = vq[i].e_ifpc + 16'd2;
                chk($sformatf("row%0d if_pc_plus2", i), if_pc_plus2, inc);
            end
            chk($sformatf("row%0d pc_hold", i), pc_hold, vq[i].e_hold);
            if (!vq[i].e_hold) chk($sformatf("row%0d next_pc", i), next_pc, vq[i].e_next);
            chk($sformatf("row%0d halted", i), halted, 1'b0);
            advance();
        end

        // Reset while a request is outstanding drops mem_rd immediately.
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk("midreq mem_rd before", mem_rd, 1'b1);
        chk("midreq mem_addr", mem_addr, 16'h0202);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreq mem_rd after", mem_rd, 1'b0);
        chk("midreq mem_addr after", mem_addr, 16'h0000);
        chk("midreq pc_hold", pc_hold, 1'b1);

        // Randomized run against the fetch-stream model.
        do_reset();
        req_active = 1'b0;
        req_addr   = 16'h0000;
        exp_pc     = 16'h0000;
        accepts    = 0;
        lat        = 0;
        waited     = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_r   = ($urandom_range(0, 15) == 0);
            r_rp  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_d   = 1'b0;
            r_dat = 16'($urandom);
            if (mem_rd) begin
                if (!req_active) begin
                    chk("rnd req_addr", mem_addr, exp_pc);
                    req_active = 1'b1;
                    req_addr   = mem_addr;
                    lat        = int'($urandom_range(0, 3));
                    waited     = 0;
                end else begin
                    chk("rnd addr_stable", mem_addr, req_addr);
                end
                if (waited == lat) begin
                    r_d   = 1'b1;
                    r_dat = mem_fn(mem_addr);
                end
                waited++;
            end
            drive(r_d, r_dat, r_r, r_rp, r_rdy);
            chk("rnd pc_hold", pc_hold, !(r_r || (if_valid && r_rdy)));
            inc = if_pc + 16'd2;
            if (r_r) chk("rnd next_pc redirect", next_pc, r_rp);
            else if (if_valid && r_rdy) chk("rnd next_pc inc", next_pc, inc);
            if (if_valid) begin
                chk("rnd if_pc", if_pc, exp_pc);
                chk("rnd if_instr", if_instr, mem_fn(exp_pc));
                chk("rnd rd_in_deliver", mem_rd, 1'b0);
            end else begin
                chk("rnd nop", if_instr, NOP);
            end
            chk("rnd if_pc_plus2", if_pc_plus2, inc);
            chk("rnd halted", halted, 1'b0);
            if (r_r) begin
                exp_pc = r_rp;
            end else if (if_valid && r_rdy) begin
                exp_pc = exp_pc + 16'd2;
                accepts++;
            end
            advance();
            if (r_d) req_active = 1'b0;
        end
        n_tests++;
        if (accepts < 100) begin
            n_fail++;
            $display("FAIL rnd progress: got %0d accepts expected at least 100", accepts);
        end

`ifdef IFETCH_HALT_EN
        // Accepting a HALT word stops fetch for good; redirects are ignored.
        do_reset();
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        advance();
        drive(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk("halt fetch mem_rd", mem_rd, 1'b1);
        advance();
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        chk("halt deliver if_valid", if_valid, 1'b1);
        chk("halt deliver if_instr", if_instr, 16'h0000);
        chk("halt deliver halted", halted, 1'b0);
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 16'h0000, (i % 2 == 0), 16'h0040, 1'b1);
            chk($sformatf("halt%0d halted", i), halted, 1'b1);
            chk($sformatf("halt%0d mem_rd", i), mem_rd, 1'b0);
            chk($sformatf("halt%0d pc_hold", i), pc_hold, 1'b1);
            chk($sformatf("halt%0d if_valid", i), if_valid, 1'b0);
            chk($sformatf("halt%0d if_instr", i), if_instr, NOP);
            advance();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
